// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and sequencing control for a 5-stage pipeline.
// Define FWD_EN to enable operand forwarding; without it every RAW dependency stalls.
module pipe_hazard_ctrl #(
  parameter int         CNT_W       = 16,
  parameter int         MEM_TIMEOUT = 64,
  parameter logic [4:0] HALT_OP     = 5'b11111,
  parameter int         R0_ZERO     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_op,
  input  logic [3:0]       dec_rs1,
  input  logic [3:0]       dec_rs2,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_is_branch,
  input  logic             branch_taken,
  input  logic [3:0]       exe_rs1,
  input  logic [3:0]       exe_rs2,
  input  logic [3:0]       exe_rd,
  input  logic             exe_rwrite,
  input  logic             exe_is_load,
  input  logic [3:0]       mem_rd,
  input  logic             mem_rwrite,
  input  logic             mem_is_load,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze_all,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FREEZE, HALT} state_t;

  state_t           state_q, state_d, run_next;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src1_exe, src2_exe, src1_mem, src2_mem;
  logic             data_hazard, run_stall, run_flush;

  function automatic logic match(input logic [3:0] x, input logic [3:0] rd, input logic we);
    return we && (x == rd) && !((R0_ZERO != 0) && (rd == 4'd0));
  endfunction

  assign src1_exe = dec_use_rs1 && match(dec_rs1, exe_rd, exe_rwrite);
  assign src2_exe = dec_use_rs2 && match(dec_rs2, exe_rd, exe_rwrite);
  assign src1_mem = dec_use_rs1 && match(dec_rs1, mem_rd, mem_rwrite);
  assign src2_mem = dec_use_rs2 && match(dec_rs2, mem_rd, mem_rwrite);

`ifdef FWD_EN
  logic [3:0] wb_rd_q;
  logic       wb_we_q;

  // Only a load in EX can't be forwarded to decode; branches resolve in decode, so they also wait on loads in MEM.
  assign data_hazard = (dec_valid && exe_is_load && (src1_exe || src2_exe)) ||
                       (dec_is_branch && (src1_exe || src2_exe ||
                                          (mem_is_load && (src1_mem || src2_mem))));

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_rd_q <= 4'd0;
      wb_we_q <= 1'b0;
    end else if (!freeze_all) begin
      wb_rd_q <= mem_rd;
      wb_we_q <= mem_rwrite;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (match(exe_rs1, mem_rd, mem_rwrite) && !mem_is_load) fwd_a = 2'b01;
      else if (match(exe_rs1, wb_rd_q, wb_we_q))              fwd_a = 2'b10;
      if (match(exe_rs2, mem_rd, mem_rwrite) && !mem_is_load) fwd_b = 2'b01;
      else if (match(exe_rs2, wb_rd_q, wb_we_q))              fwd_b = 2'b10;
    end
  end
`else
  logic unused_nofwd;

  assign data_hazard  = dec_valid && (src1_exe || src2_exe || src1_mem || src2_mem);
  assign fwd_a        = 2'b00;
  assign fwd_b        = 2'b00;
  assign unused_nofwd = ^{exe_rs1, exe_rs2, exe_is_load, mem_is_load, dec_is_branch};
`endif

  always_comb begin
    run_stall = 1'b0;
    run_flush = 1'b0;
    run_next  = RUN;
    if (dec_valid && (dec_op == HALT_OP)) begin
      run_stall = 1'b1;
      run_next  = HALT;
    end else if (data_hazard) begin
      run_stall = 1'b1;
    end else if (branch_taken) begin
      run_flush = 1'b1;
    end
  end

  // A FREEZE release cycle behaves like a RUN cycle so decode hazards are not skipped.
  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    err_d      = err_q;
    stall_if   = 1'b0;
    flush_id   = 1'b0;
    bubble_ex  = 1'b0;
    freeze_all = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_all = 1'b1;
          tmo_d      = TW'(1);
          state_d    = FREEZE;
        end else begin
          stall_if  = run_stall;
          bubble_ex = run_stall;
          flush_id  = run_flush;
          state_d   = run_next;
        end
      end
      FREEZE: begin
        if (mem_ready) begin
          stall_if  = run_stall;
          bubble_ex = run_stall;
          flush_id  = run_flush;
          state_d   = run_next;
        end else if (tmo_q >= TW'(MEM_TIMEOUT - 1)) begin
          freeze_all = 1'b1;
          err_d      = 1'b1;
          state_d    = HALT;
        end else begin
          freeze_all = 1'b1;
          tmo_d      = tmo_q + TW'(1);
        end
      end
      HALT: begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      state_d    = RUN;
      tmo_d      = '0;
      err_d      = 1'b0;
      stall_if   = 1'b0;
      flush_id   = 1'b0;
      bubble_ex  = 1'b0;
      freeze_all = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall_if || freeze_all) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted          = !reset && (state_q == HALT);
  assign mem_timeout_err = !reset && err_q;
  assign stall_cycles    = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expectations follow the FWD_EN build setting.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_op;
    logic [3:0] dec_rs1, dec_rs2;
    logic       dec_use_rs1, dec_use_rs2, dec_is_branch, branch_taken;
    logic [3:0] exe_rs1, exe_rs2, exe_rd;
    logic       exe_rwrite, exe_is_load;
    logic [3:0] mem_rd;
    logic       mem_rwrite, mem_is_load, mem_req, mem_ready;
  } stim_t;

  typedef struct packed {
    logic        stall_if, flush_id, bubble_ex, freeze_all;
    logic [1:0]  fwd_a, fwd_b;
    logic        halted, err;
    logic [15:0] cnt;
  } outs_t;

  localparam logic [3:0] NONE  = 4'b0000;
  localparam logic [3:0] STALL = 4'b1010;
  localparam logic [3:0] FLUSH = 4'b0100;
  localparam logic [3:0] FRZ   = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dec_valid = 1'b0, dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
  logic dec_is_branch = 1'b0, branch_taken = 1'b0;
  logic [4:0] dec_op = 5'd0;
  logic [3:0] dec_rs1 = 4'd0, dec_rs2 = 4'd0, exe_rs1 = 4'd0, exe_rs2 = 4'd0, exe_rd = 4'd0, mem_rd = 4'd0;
  logic exe_rwrite = 1'b0, exe_is_load = 1'b0, mem_rwrite = 1'b0, mem_is_load = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic stall_if, flush_id, bubble_ex, freeze_all, halted, mem_timeout_err;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  outs_t expQ[$];
  logic [15:0] expCnt = 16'd0;
  int nChecks = 0;
  int nFails  = 0;

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64), .HALT_OP(5'b11111), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_is_branch(dec_is_branch), .branch_taken(branch_taken),
    .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rd(exe_rd),
    .exe_rwrite(exe_rwrite), .exe_is_load(exe_is_load),
    .mem_rd(mem_rd), .mem_rwrite(mem_rwrite), .mem_is_load(mem_is_load),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .flush_id(flush_id), .bubble_ex(bubble_ex), .freeze_all(freeze_all),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                               input logic h, input logic er);
    outs_t o;
    o = '0;
    {o.stall_if, o.flush_id, o.bubble_ex, o.freeze_all} = ctl;
    o.fwd_a  = fa;
    o.fwd_b  = fb;
    o.halted = h;
    o.err    = er;
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o = {stall_if, flush_id, bubble_ex, freeze_all, fwd_a, fwd_b, halted, mem_timeout_err, stall_cycles};
    return o;
  endfunction

  // Drives one cycle of inputs and queues its expectation, stamped with the modelled stall count.
  task automatic applyStimulus(input stim_t s, input outs_t e);
    outs_t q;
    @(negedge clk);
    reset = s.reset; dec_valid = s.dec_valid; dec_op = s.dec_op;
    dec_rs1 = s.dec_rs1; dec_rs2 = s.dec_rs2; dec_use_rs1 = s.dec_use_rs1; dec_use_rs2 = s.dec_use_rs2;
    dec_is_branch = s.dec_is_branch; branch_taken = s.branch_taken;
    exe_rs1 = s.exe_rs1; exe_rs2 = s.exe_rs2; exe_rd = s.exe_rd;
    exe_rwrite = s.exe_rwrite; exe_is_load = s.exe_is_load;
    mem_rd = s.mem_rd; mem_rwrite = s.mem_rwrite; mem_is_load = s.mem_is_load;
    mem_req = s.mem_req; mem_ready = s.mem_ready;
    q = e;
    q.cnt = s.reset ? 16'd0 : expCnt;
    expQ.push_back(q);
    if (s.reset) expCnt = 16'd0;
    else if ((e.stall_if || e.freeze_all) && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
  endtask

  task automatic test_reset();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    s = '0; s.reset = 1; s.mem_req = 1; s.dec_valid = 1; s.dec_op = 5'b11111; s.branch_taken = 1;
    s.exe_rs1 = 4'd2; s.mem_rd = 4'd2; s.mem_rwrite = 1;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s = '0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL reset[%0d] got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_load_use();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    s = '0; s.dec_valid = 1; s.dec_use_rs1 = 1; s.dec_rs1 = 4'd3;
    s.exe_rd = 4'd3; s.exe_rwrite = 1; s.exe_is_load = 1;
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 0, 0));
    s.exe_rd = 4'd0; s.exe_rwrite = 0; s.exe_is_load = 0;
    s.mem_rd = 4'd3; s.mem_rwrite = 1; s.mem_is_load = 1;
`ifdef FWD_EN
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
`else
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 0, 0));
    s.mem_rd = 4'd0; s.mem_rwrite = 0; s.mem_is_load = 0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
`endif
    s = '0; s.exe_rs1 = 4'd3; s.exe_rd = 4'd4; s.exe_rwrite = 1;
    sq.push_back(s);
`ifdef FWD_EN
    eq.push_back(mk(NONE, 2'b10, 2'b00, 0, 0));
`else
    eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
`endif
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL load_use[%0d] got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_forward_priority();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    logic [1:0] f01, f10;
`ifdef FWD_EN
    f01 = 2'b01; f10 = 2'b10;
`else
    f01 = 2'b00; f10 = 2'b00;
`endif
    s = '0; s.mem_rd = 4'd5; s.mem_rwrite = 1; s.exe_rs2 = 4'd5;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, f01, 0, 0));
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, f01, 0, 0));
    s.mem_rwrite = 0; s.exe_rs1 = 4'd5;
    sq.push_back(s); eq.push_back(mk(NONE, f10, f10, 0, 0));
    s.mem_rwrite = 1; s.mem_is_load = 1; s.exe_rs1 = 4'd0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s = '0; s.mem_rd = 4'd0; s.mem_rwrite = 1; s.exe_rs2 = 4'd0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL fwd_priority[%0d] got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_branch();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    s = '0; s.dec_valid = 1; s.dec_is_branch = 1; s.branch_taken = 1;
    s.dec_use_rs1 = 1; s.dec_rs1 = 4'd1; s.dec_use_rs2 = 1; s.dec_rs2 = 4'd2;
    sq.push_back(s); eq.push_back(mk(FLUSH, 2'b00, 2'b00, 0, 0));
    s = '0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s.dec_valid = 1; s.dec_is_branch = 1; s.branch_taken = 1; s.dec_use_rs1 = 1; s.dec_rs1 = 4'd6;
    s.exe_rd = 4'd6; s.exe_rwrite = 1; s.exe_is_load = 1;
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 0, 0));
    s.exe_rd = 4'd0; s.exe_rwrite = 0; s.exe_is_load = 0;
    s.mem_rd = 4'd6; s.mem_rwrite = 1; s.mem_is_load = 1;
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 0, 0));
    s.mem_rd = 4'd0; s.mem_rwrite = 0; s.mem_is_load = 0;
    sq.push_back(s); eq.push_back(mk(FLUSH, 2'b00, 2'b00, 0, 0));
    s = '0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s.dec_valid = 1; s.dec_use_rs2 = 1; s.dec_rs2 = 4'd7; s.exe_rd = 4'd7; s.exe_rwrite = 1;
    sq.push_back(s);
`ifdef FWD_EN
    eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
`else
    eq.push_back(mk(STALL, 2'b00, 2'b00, 0, 0));
`endif
    s = '0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL branch[%0d] got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_freeze();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    s = '0; s.mem_req = 1;
    sq.push_back(s); eq.push_back(mk(FRZ, 2'b00, 2'b00, 0, 0));
    s.branch_taken = 1;
    sq.push_back(s); eq.push_back(mk(FRZ, 2'b00, 2'b00, 0, 0));
    s.branch_taken = 0;
    sq.push_back(s); eq.push_back(mk(FRZ, 2'b00, 2'b00, 0, 0));
    s.mem_ready = 1;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s = '0; s.branch_taken = 1;
    sq.push_back(s); eq.push_back(mk(FLUSH, 2'b00, 2'b00, 0, 0));
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL freeze[%0d] got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_timeout();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    s = '0; s.mem_req = 1;
    for (int k = 0; k < 64; k++) begin
      sq.push_back(s); eq.push_back(mk(FRZ, 2'b00, 2'b00, 0, 0));
    end
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 1, 1));
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 1, 1));
    s.reset = 1;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s = '0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL timeout[%0d] got %h required %h", i, got, e); end
    end
  endtask

  task automatic test_halt();
    stim_t s; stim_t sq[$]; outs_t eq[$]; outs_t e, got;
    s = '0; s.dec_valid = 1; s.dec_op = 5'b11111;
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 0, 0));
    s = '0;
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 1, 0));
    s.branch_taken = 1; s.mem_req = 1;
    sq.push_back(s); eq.push_back(mk(STALL, 2'b00, 2'b00, 1, 0));
    s = '0; s.reset = 1;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s = '0;
    sq.push_back(s); eq.push_back(mk(NONE, 2'b00, 2'b00, 0, 0));
    s.branch_taken = 1;
    sq.push_back(s); eq.push_back(mk(FLUSH, 2'b00, 2'b00, 0, 0));
    foreach (sq[i]) begin
      applyStimulus(sq[i], eq[i]);
      #1;
      got = observed(); e = expQ.pop_front(); nChecks++;
      if (got !== e) begin nFails++; $display("[TB] FAIL halt[%0d] got %h required %h", i, got, e); end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_forward_priority();
    test_branch();
    test_freeze();
    test_timeout();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback).
- Detects RAW hazards between decode sources and in-flight destinations.
- Generates operand-forwarding selects for the execute stage.
- Drives stall, bubble, flush and freeze controls for the pipeline registers.
- Handles taken-branch flush, data-memory wait states, memory timeout and HALT.

Parameters:
- CNT_W, 16, width of saturating stall-cycle counter
- MEM_TIMEOUT, 64, max consecutive FREEZE cycles before error
- HALT_OP, 5'b11111, decode opcode (Inst[31:27]) that halts fetch
- R0_ZERO, 0, 1 = register 0 is hardwired and never creates a hazard

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_valid  in  1  decode stage holds a real instruction
- dec_op  in  5  decode opcode
- dec_rs1  in  4  decode source register 1
- dec_rs2  in  4  decode source register 2
- dec_use_rs1  in  1  decode reads rs1
- dec_use_rs2  in  1  decode reads rs2
- dec_is_branch  in  1  decode instruction is a compare/branch
- branch_taken  in  1  decode branch resolved taken (PC select)
- exe_rs1  in  4  execute stage source register 1
- exe_rs2  in  4  execute stage source register 2
- exe_rd  in  4  execute destination
- exe_rwrite  in  1  execute instruction writes the register file
- exe_is_load  in  1  execute instruction takes its result from data memory
- mem_rd  in  4  memory stage destination
- mem_rwrite  in  1  memory instruction writes the register file
- mem_is_load  in  1  memory instruction is a load
- mem_req  in  1  memory stage accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC and IF/ID
- flush_id  out  1  IF/ID loads NOP
- bubble_ex  out  1  ID/EX loads NOP (write enables cleared)
- freeze_all  out  1  hold every pipeline register and PC
- fwd_a  out  2  execute operand A select
- fwd_b  out  2  execute operand B select
- halted  out  1  in HALT state
- mem_timeout_err  out  1  sticky memory timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if or freeze_all

Behaviour:
- Register file is write-first. A writeback-stage destination never causes a hazard.
- match(x, rd, we): we=1, x==rd, and not (R0_ZERO=1 and rd==0).
- States: RUN, FREEZE, HALT. State is registered; control outputs are combinational from state and inputs.
- Reset:
  - While reset is high, all outputs are 0 and fwd_a/fwd_b are 00.
  - On the next edge: state=RUN, timeout counter=0, stall_cycles=0, mem_timeout_err=0.
  - Reset mid-FREEZE or in HALT returns to RUN immediately.
- Priority in RUN, highest first:
  1. mem_req and not mem_ready: freeze_all=1; go to FREEZE.
  2. dec_valid and dec_op==HALT_OP: stall_if=1, bubble_ex=1; go to HALT.
  3. Load-use:
     - Condition: dec_valid, exe_is_load, and a used source matches (exe_rd, exe_rwrite).
     - Response: stall_if=1, bubble_ex=1 for exactly 1 cycle.
  4. Branch hazard:
     - Condition: dec_is_branch, and a used source matches (exe_rd, exe_rwrite) or matches (mem_rd, mem_rwrite) with mem_is_load.
     - Response: stall_if=1, bubble_ex=1.
  5. branch_taken (only when no stall above): flush_id=1 for 1 cycle; PC is not held.
- branch_taken is ignored in any cycle where stall_if or freeze_all is asserted; it is re-evaluated next cycle.
- FREEZE:
  - freeze_all=1 every cycle; the timeout counter increments.
  - mem_ready=1: release in that same cycle, i.e. freeze_all=0 and the pipeline advances; next state RUN; counter cleared.
  - Counter reaches MEM_TIMEOUT-1 without ready: mem_timeout_err=1 (sticky until reset); go to HALT.
- HALT: stall_if=1 and bubble_ex=1 continuously; halted=1. The pipeline drains. Exit only via reset.
- Forwarding (execute operands; fwd_b mirrors fwd_a using exe_rs2):
  - 01 if match(exe_rs1, mem_rd, mem_rwrite) and not mem_is_load (ALU result in EX/MEM).
  - Otherwise 10 if the writeback-stage producer matches. Its destination is tracked internally by registering mem_rd/mem_rwrite when the pipeline is not frozen; the MEM/WB result is forwarded.
  - Otherwise 00.
  - The nearer stage wins over the farther one.
- stall_cycles increments on any cycle with stall_if or freeze_all. It saturates at all-ones and does not wrap.

Optional Feature:
- FWD_EN defined: forwarding as above.
- FWD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - Any used decode source matching (exe_rd, exe_rwrite) or (mem_rd, mem_rwrite) stalls, with stall_if=1 and bubble_ex=1, until no match remains.
  - The load-use and branch rules collapse into this rule.

Test Plan:
- Load r3 in EXE; decode add uses rs1=3 → exactly 1 cycle stall_if=1, bubble_ex=1. Next cycle fwd_a=10 (FWD_EN). stall_cycles=1.
- ALU write r5 in MEM, EXE reads rs2=5, WB also writes r5 → fwd_b=01 (nearer stage wins). With R0_ZERO=1, r0 match → fwd_b=00.
- branch_taken=1 with no hazard → flush_id=1 for 1 cycle, stall_if=0. The same branch with a load-use hazard → stall first, flush on the following cycle.
- mem_req=1, mem_ready low 3 cycles then high → freeze_all=1 for 3 cycles, 0 on the ready cycle. Final state RUN, stall_cycles=3.
- mem_req=1, mem_ready never → after MEM_TIMEOUT=64 cycles: mem_timeout_err=1, halted=1. Reset clears both on the next edge.
- Decode dec_op=5'b11111 → halted=1 and stall_if=1 held. Assert reset mid-HALT → state RUN, all outputs 0.
